// File: rtl/pipelined_barrel_shifter.sv
// Pipelined SLL/SRL/SRA/ROL barrel shifter: log2(WIDTH) mux levels, REG_EVERY levels per stage.
// Define BARREL_SHIFTER_STICKY_EN to add the sticky output (OR of bits shifted out on right shifts).
module pipelined_barrel_shifter #(
  parameter int WIDTH     = 32,
  parameter int SHAMT_W   = 5,
  parameter int REG_EVERY = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result
`ifdef BARREL_SHIFTER_STICKY_EN
  ,
  output logic               sticky
`endif
);

  localparam int NST = (SHAMT_W + REG_EVERY - 1) / REG_EVERY;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  if (SHAMT_W != $clog2(WIDTH) || WIDTH < 4 || REG_EVERY < 1 || REG_EVERY > SHAMT_W) begin : g_bad_params
    $error("pipelined_barrel_shifter: illegal WIDTH/SHAMT_W/REG_EVERY combination");
  end

  // One mux level: shift by n, with the original operand's sign as the SRA fill.
  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input logic [1:0]       o,
                                                   input logic             sgn,
                                                   input int               n);
    logic signed [WIDTH:0] ext;
    logic [WIDTH-1:0]      r;
    ext = $signed({sgn, d}) >>> n;
    case (o)
      OP_SLL:  r = d << n;
      OP_SRL:  r = d >> n;
      OP_SRA:  r = ext[WIDTH-1:0];
      default: r = (d << n) | (d >> (WIDTH - n));
    endcase
    return r;
  endfunction

  // Bits that drop off the LSB end when d is shifted right by n.
  function automatic logic lost_bits(input logic [WIDTH-1:0] d, input int n);
    logic [WIDTH-1:0] m;
    m = ~({WIDTH{1'b1}} << n);
    return |(d & m);
  endfunction

  logic adv;

  for (genvar s = 0; s < NST; s++) begin : g_stage
    localparam int LO = s * REG_EVERY;
    localparam int HI = (LO + REG_EVERY > SHAMT_W) ? SHAMT_W : LO + REG_EVERY;

    logic [WIDTH-1:0]   src_d;
    logic [1:0]         src_op;
    logic [SHAMT_W-1:0] src_sh;
    logic               src_sgn;
    logic               src_vld;
    logic               src_stk;

    logic [WIDTH-1:0]   nxt_d;
    logic               nxt_stk;

    logic [WIDTH-1:0]   d_p;
    logic [1:0]         op_p;
    logic [SHAMT_W-1:0] sh_p;
    logic               sgn_p;
    logic               vld_p;
    logic               stk_p;

    if (s == 0) begin : g_head
      assign src_d   = data;
      assign src_op  = op;
      assign src_sh  = shamt;
      assign src_sgn = data[WIDTH-1];
      assign src_vld = in_valid;
      assign src_stk = 1'b0;
    end else begin : g_body
      assign src_d   = g_stage[s-1].d_p;
      assign src_op  = g_stage[s-1].op_p;
      assign src_sh  = g_stage[s-1].sh_p;
      assign src_sgn = g_stage[s-1].sgn_p;
      assign src_vld = g_stage[s-1].vld_p;
      assign src_stk = g_stage[s-1].stk_p;
    end

    always_comb begin
      nxt_d   = src_d;
      nxt_stk = src_stk;
      for (int l = LO; l < HI; l++) begin
        if (src_sh[l]) begin
          nxt_stk = nxt_stk | ((src_op == OP_SRL || src_op == OP_SRA) && lost_bits(nxt_d, 1 << l));
          nxt_d   = shift_level(nxt_d, src_op, src_sgn, 1 << l);
        end
      end
    end

    // Stage boundary: the whole pipe moves together on adv, otherwise every field holds.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        d_p   <= '0;
        op_p  <= '0;
        sh_p  <= '0;
        sgn_p <= 1'b0;
        vld_p <= 1'b0;
        stk_p <= 1'b0;
      end else if (adv) begin
        d_p   <= nxt_d;
        op_p  <= src_op;
        sh_p  <= src_sh;
        sgn_p <= src_sgn;
        vld_p <= src_vld;
`ifdef BARREL_SHIFTER_STICKY_EN
        stk_p <= nxt_stk;
`else
        stk_p <= 1'b0;
`endif
      end
    end

    // Each stage only consumes its own shamt bits; the tail stage's control fields go nowhere.
    logic unused_stage;
    assign unused_stage = ^{src_sh, op_p, sh_p, sgn_p, stk_p, nxt_stk};
  end

  assign out_valid = g_stage[NST-1].vld_p;
  assign result    = g_stage[NST-1].d_p;
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

`ifdef BARREL_SHIFTER_STICKY_EN
  assign sticky = g_stage[NST-1].stk_p;
`endif

endmodule
